// File: rtl/vedic_4x4_sequencer_if.sv
// Bus bundle for vedic_4x4_sequencer.
// Carries three streams and one digit-multiplier link:
//   s_a_*       operand A stream into the sequencer (4-bit)
//   s_b_*       operand B stream into the sequencer (4-bit)
//   mul_a_*     A digit issued to the external 2x2 multiplier (2-bit)
//   mul_b_*     B digit issued to the external 2x2 multiplier (2-bit)
//   mul_*       partial product returned by the multiplier (4-bit)
//   m_*         final 8-bit product out of the sequencer
// slave  : the sequencer's view.
// master : the environment's view (operand source, multiplier, result sink).
interface vedic_4x4_sequencer_if;
    logic [3:0] s_a_tdata;
    logic       s_a_tvalid;
    logic       s_a_tready;
    logic [3:0] s_b_tdata;
    logic       s_b_tvalid;
    logic       s_b_tready;
    logic [1:0] mul_a_tdata;
    logic       mul_a_tvalid;
    logic       mul_a_tready;
    logic [1:0] mul_b_tdata;
    logic       mul_b_tvalid;
    logic       mul_b_tready;
    logic [3:0] mul_result_tdata;
    logic       mul_tvalid;
    logic       mul_tready;
    logic [7:0] m_result_tdata;
    logic       m_tvalid;
    logic       m_tready;

    modport slave (
        input  s_a_tdata, s_a_tvalid, output s_a_tready,
        input  s_b_tdata, s_b_tvalid, output s_b_tready,
        output mul_a_tdata, mul_a_tvalid, input mul_a_tready,
        output mul_b_tdata, mul_b_tvalid, input mul_b_tready,
        input  mul_result_tdata, mul_tvalid, output mul_tready,
        output m_result_tdata, m_tvalid, input m_tready
    );

    modport master (
        output s_a_tdata, s_a_tvalid, input s_a_tready,
        output s_b_tdata, s_b_tvalid, input s_b_tready,
        input  mul_a_tdata, mul_a_tvalid, output mul_a_tready,
        input  mul_b_tdata, mul_b_tvalid, output mul_b_tready,
        output mul_result_tdata, mul_tvalid, input mul_tready,
        input  m_result_tdata, m_tvalid, output m_tready
    );
endinterface

// File: rtl/vedic_4x4_sequencer.sv
// 4x4 unsigned multiplier sequencer using the Vedic digit decomposition.
// Captures A and B independently, then issues the four 2-bit digit pairs
// to an external 2x2 multiplier one at a time, accumulating each shifted
// partial product into an 8-bit result presented on the m_* stream.
// Ports:
//   clk     rising-edge clock
//   arst_n  asynchronous active-low reset
//   bus     vedic_4x4_sequencer_if.slave (operand, multiplier and result streams)
module vedic_4x4_sequencer (
    input  logic                        clk,
    input  logic                        arst_n,
    vedic_4x4_sequencer_if.slave        bus
);
    localparam int unsigned OP_W  = 4;
    localparam int unsigned DIG_W = 2;
    localparam int unsigned ACC_W = 8;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned SH_W  = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [OP_W-1:0]    a_q, a_d;
    logic [OP_W-1:0]    b_q, b_d;
    logic               s_a_tready_q, s_a_tready_d;
    logic               s_b_tready_q, s_b_tready_d;
    logic               mul_a_tvalid_q, mul_a_tvalid_d;
    logic               mul_b_tvalid_q, mul_b_tvalid_d;
    logic [DIG_W-1:0]   mul_a_tdata_q, mul_a_tdata_d;
    logic [DIG_W-1:0]   mul_b_tdata_q, mul_b_tdata_d;
    logic               mul_tready_q, mul_tready_d;
    logic               m_tvalid_q, m_tvalid_d;
    logic [ACC_W-1:0]   m_result_q, m_result_d;

    logic [SH_W-1:0]    shift_c;
    logic               load_digits_c;

    // Digit weight: idx0 -> 0, idx1/idx2 -> 2, idx3 -> 4.
    assign shift_c = {idx_q[1] & idx_q[0], idx_q[1] ^ idx_q[0], 1'b0};

    // State and output registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            acc_q          <= '0;
            a_q            <= '0;
            b_q            <= '0;
            s_a_tready_q   <= 1'b1;
            s_b_tready_q   <= 1'b1;
            mul_a_tvalid_q <= 1'b0;
            mul_b_tvalid_q <= 1'b0;
            mul_a_tdata_q  <= '0;
            mul_b_tdata_q  <= '0;
            mul_tready_q   <= 1'b0;
            m_tvalid_q     <= 1'b0;
            m_result_q     <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            acc_q          <= acc_d;
            a_q            <= a_d;
            b_q            <= b_d;
            s_a_tready_q   <= s_a_tready_d;
            s_b_tready_q   <= s_b_tready_d;
            mul_a_tvalid_q <= mul_a_tvalid_d;
            mul_b_tvalid_q <= mul_b_tvalid_d;
            mul_a_tdata_q  <= mul_a_tdata_d;
            mul_b_tdata_q  <= mul_b_tdata_d;
            mul_tready_q   <= mul_tready_d;
            m_tvalid_q     <= m_tvalid_d;
            m_result_q     <= m_result_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        acc_d          = acc_q;
        a_d            = a_q;
        b_d            = b_q;
        s_a_tready_d   = s_a_tready_q;
        s_b_tready_d   = s_b_tready_q;
        mul_a_tvalid_d = mul_a_tvalid_q;
        mul_b_tvalid_d = mul_b_tvalid_q;
        mul_a_tdata_d  = mul_a_tdata_q;
        mul_b_tdata_d  = mul_b_tdata_q;
        mul_tready_d   = mul_tready_q;
        m_tvalid_d     = m_tvalid_q;
        m_result_d     = m_result_q;
        load_digits_c  = 1'b0;

        // Operands capture independently; a low tready means "operand held".
        if (bus.s_a_tvalid && s_a_tready_q) begin
            a_d          = bus.s_a_tdata;
            s_a_tready_d = 1'b0;
        end
        if (bus.s_b_tvalid && s_b_tready_q) begin
            b_d          = bus.s_b_tdata;
            s_b_tready_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!s_a_tready_q && !s_b_tready_q) begin
                    state_d        = ISSUE;
                    idx_d          = '0;
                    acc_d          = '0;
                    mul_a_tvalid_d = 1'b1;
                    mul_b_tvalid_d = 1'b1;
                    load_digits_c  = 1'b1;
                end
            end
            ISSUE: begin
                // Each digit stream retires on its own handshake.
                if (bus.mul_a_tready) mul_a_tvalid_d = 1'b0;
                if (bus.mul_b_tready) mul_b_tvalid_d = 1'b0;
                if (!mul_a_tvalid_d && !mul_b_tvalid_d) begin
                    state_d      = WAIT;
                    mul_tready_d = 1'b1;
                end
            end
            WAIT: begin
                if (bus.mul_tvalid && mul_tready_q) begin
                    acc_d        = acc_q + (ACC_W'(bus.mul_result_tdata) << shift_c);
                    mul_tready_d = 1'b0;
                    if (idx_q != IDX_W'(3)) begin
                        idx_d          = idx_q + IDX_W'(1);
                        state_d        = ISSUE;
                        mul_a_tvalid_d = 1'b1;
                        mul_b_tvalid_d = 1'b1;
                        load_digits_c  = 1'b1;
                    end else begin
                        state_d    = DONE;
                        m_tvalid_d = 1'b1;
                        m_result_d = acc_d;
                    end
                end
            end
            DONE: begin
                if (bus.m_tready) begin
                    state_d      = IDLE;
                    m_tvalid_d   = 1'b0;
                    s_a_tready_d = 1'b1;
                    s_b_tready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Digit pair for the index being entered: idx[1] picks A half, idx[0] picks B half.
        if (load_digits_c) begin
            mul_a_tdata_d = idx_d[1] ? a_q[3:2] : a_q[1:0];
            mul_b_tdata_d = idx_d[0] ? b_q[3:2] : b_q[1:0];
        end
    end

    assign bus.s_a_tready     = s_a_tready_q;
    assign bus.s_b_tready     = s_b_tready_q;
    assign bus.mul_a_tvalid   = mul_a_tvalid_q;
    assign bus.mul_b_tvalid   = mul_b_tvalid_q;
    assign bus.mul_a_tdata    = mul_a_tdata_q;
    assign bus.mul_b_tdata    = mul_b_tdata_q;
    assign bus.mul_tready     = mul_tready_q;
    assign bus.m_tvalid       = m_tvalid_q;
    assign bus.m_result_tdata = m_result_q;
endmodule
